// File: rtl/addr_4bit.sv
// Registered 4-bit adder/subtractor with sign-magnitude 5-bit result, one-cycle latency.
// Optional Zero flag output enabled by defining ADDR4BIT_ZERO_FLAG_EN.
module addr_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  output logic       out_valid,
  output logic       Sign,
  output logic [4:0] S
`ifdef ADDR4BIT_ZERO_FLAG_EN
  ,
  output logic       Zero
`endif
);

  logic [3:0] w_b;
  logic [4:0] w_c;
  logic [3:0] w_sum;
  logic [3:0] w_neg;
  logic [4:0] w_s_nxt;
  logic       w_sign_nxt;

  logic       r_out_valid;
  logic       r_sign;
  logic [4:0] r_s;

  // Subtract is A + ~B + 1: invert B and inject M as the carry-in.
  assign w_b    = B ^ {4{M}};
  assign w_c[0] = M;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_fa
      assign w_sum[gi]  = A[gi] ^ w_b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (A[gi] & w_b[gi]) | (w_c[gi] & (A[gi] ^ w_b[gi]));
    end
  endgenerate

  assign w_neg = ~w_sum + 4'd1;

  // Map the raw ripple sum onto sign-magnitude form.
  always_comb begin
    w_s_nxt    = 5'd0;
    w_sign_nxt = 1'b0;
    if (!M) begin
      w_s_nxt    = {w_c[4], w_sum};
      w_sign_nxt = 1'b0;
    end else if (w_c[4]) begin
      w_s_nxt    = {1'b0, w_sum};
      w_sign_nxt = 1'b0;
    end else begin
      w_s_nxt    = {1'b0, w_neg};
      w_sign_nxt = 1'b1;
    end
  end

  // Result register: reset wins over a same-cycle input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_s         <= 5'd0;
    end else if (in_valid) begin
      r_out_valid <= 1'b1;
      r_sign      <= w_sign_nxt;
      r_s         <= w_s_nxt;
    end else begin
      r_out_valid <= 1'b0;
      r_sign      <= r_sign;
      r_s         <= r_s;
    end
  end

  assign out_valid = r_out_valid;
  assign Sign      = r_sign;
  assign S         = r_s;

`ifdef ADDR4BIT_ZERO_FLAG_EN
  assign Zero = (r_s == 5'd0);
`endif

endmodule

// File: tb/tb_addr_4bit.sv
// Self-checking bench for addr_4bit: directed plan vectors then randomized traffic
// compared against an arithmetic reference model.
module tb_addr_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       M;
  logic       out_valid;
  logic       Sign;
  logic [4:0] S;
`ifdef ADDR4BIT_ZERO_FLAG_EN
  logic       Zero;
`endif

  int n_vec;
  int n_err;

  int exp_valid;
  int exp_sign;
  int exp_s;

  addr_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .M         (M),
    .out_valid (out_valid),
    .Sign      (Sign),
    .S         (S)
`ifdef ADDR4BIT_ZERO_FLAG_EN
    ,
    .Zero      (Zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Plain-arithmetic reference: signed difference folded into sign and magnitude.
  task automatic ref_model(input int a, input int b, input int m, output int s, output int sg);
    int d;
    if (m == 0) begin
      s  = a + b;
      sg = 0;
    end else begin
      d  = a - b;
      sg = (d < 0) ? 1 : 0;
      s  = (d < 0) ? -d : d;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the falling edge.
  task automatic step(input string tag, input logic rst, input logic iv,
                      input logic [3:0] a, input logic [3:0] b, input logic m);
    int s, sg;
    rst_n    = rst;
    in_valid = iv;
    A        = a;
    B        = b;
    M        = m;
    @(posedge clk);
    if (!rst) begin
      exp_valid = 0;
      exp_sign  = 0;
      exp_s     = 0;
    end else if (iv) begin
      ref_model(int'(a), int'(b), int'(m), s, sg);
      exp_valid = 1;
      exp_sign  = sg;
      exp_s     = s;
    end else begin
      exp_valid = 0;
    end
    @(negedge clk);
    chk({tag, ".out_valid"}, int'(out_valid), exp_valid);
    chk({tag, ".Sign"}, int'(Sign), exp_sign);
    chk({tag, ".S"}, int'(S), exp_s);
`ifdef ADDR4BIT_ZERO_FLAG_EN
    chk({tag, ".Zero"}, int'(Zero), (exp_s == 0) ? 1 : 0);
`endif
  endtask

  logic [3:0] dir_a [9] = '{4'd10, 4'd5,  4'd3, 4'd15, 4'd12, 4'd7,  4'd0,  4'd0, 4'd5};
  logic [3:0] dir_b [9] = '{4'd3,  4'd14, 4'd5, 4'd15, 4'd6,  4'd12, 4'd15, 4'd0, 4'd5};
  logic       dir_m [9] = '{1'b0,  1'b0,  1'b0, 1'b0,  1'b1,  1'b1,  1'b1,  1'b1, 1'b1};

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_valid = 0;
    exp_sign  = 0;
    exp_s     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = 4'd0;
    B         = 4'd0;
    M         = 1'b0;
    @(negedge clk);

    // Reset held two cycles with a live input that must be discarded.
    step("rst0", 1'b0, 1'b1, 4'd9, 4'd9, 1'b0);
    step("rst1", 1'b0, 1'b1, 4'd9, 4'd9, 1'b0);

    // Plan vectors back to back, ending on 5-5.
    for (int i = 0; i < 9; i++)
      step($sformatf("dir%0d", i), 1'b1, 1'b1, dir_a[i], dir_b[i], dir_m[i]);

    // Idle cycles with changing operands: result must hold.
    for (int i = 0; i < 4; i++)
      step($sformatf("hold%0d", i), 1'b1, 1'b0, 4'($urandom_range(15)),
           4'($urandom_range(15)), 1'($urandom_range(1)));

    step("pre_rst", 1'b1, 1'b1, 4'd7, 4'd12, 1'b1);
    step("mid_rst", 1'b0, 1'b1, 4'd15, 4'd15, 1'b0);

    for (int i = 0; i < 400; i++)
      step($sformatf("rnd%0d", i), ($urandom_range(31) != 0), ($urandom_range(3) != 0),
           4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
